dc_stage: RTL and testbench
===========================

DC_STAGE -- requirements
Module: dc_stage

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: flush  in  1  squash stage contents.
REQ-004 SHALL have port: stall  in  6  pipeline stall vector; bit 4 = this stage's input register, bit 5 = downstream (WB) register; 1 = Stop.
REQ-005 SHALL have port: ex_to_dc_bus  in  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], alu_result[31:0]}.
REQ-006 SHALL have port: data_sram_rdata  in  32  data SRAM read data; valid exactly one cycle after the EX-stage request.
REQ-007 SHALL have port: dc_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-008 SHALL have ports: fwd_we  out  1, fwd_waddr  out  5, fwd_wdata  out  32  bypass of this stage's pending write.
REQ-009 SHALL have port: stallreq_load  out  1  a load occupies this stage and its result is not yet forwardable.

Function
REQ-010 SHALL hold an input register of all ex_to_dc_bus fields (pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, alu_result).
REQ-011 Register update priority: rst > flush > (stall[4]=1 and stall[5]=0) > stall[4]=0 > hold.
REQ-012 rst, flush, and bubble case (stall[4]=1, stall[5]=0) SHALL load all-zero fields; stall[4]=0 SHALL load ex_to_dc_bus; stall[4]=1 and stall[5]=1 SHALL hold.
REQ-013 A 1-bit first flag SHALL be set to 1 on a cycle in which the register loads from ex_to_dc_bus, and cleared otherwise.
REQ-014 Load = data_ram_en=1, data_ram_wen=4'b0000, sel_rf_res=1.
REQ-015 Read-data hold: 32-bit rdata_hold plus hold_valid; at the clock edge ending a cycle with first=1, a load present, and the register not advancing (stall[4]=1), SHALL capture data_sram_rdata and set hold_valid=1.
REQ-016 hold_valid SHALL clear on rst, flush, or any register load/bubble.
REQ-017 load_data SHALL equal rdata_hold when hold_valid=1, else data_sram_rdata.
REQ-018 rf_wdata SHALL equal load_data when sel_rf_res=1, else alu_result; combinational, zero added latency.
REQ-019 dc_to_wb_bus SHALL present registered pc, rf_we, rf_waddr and rf_wdata.
REQ-020 fwd_we SHALL equal rf_we and fwd_waddr SHALL equal rf_waddr; fwd_wdata SHALL equal rf_wdata.
REQ-021 fwd_we SHALL be forced to 0 when rf_waddr=0.
REQ-022 stallreq_load SHALL be 1 iff a load is held, rf_we=1, first=0, and hold_valid=0; this state is unreachable in legal operation and serves as a diagnostic.
REQ-023 Stores (wen nonzero) SHALL pass alu_result and rf_we unchanged; no read-data use.
REQ-024 flush concurrent with stall SHALL still zero the register (flush wins).
REQ-025 Back-to-back loads without stall SHALL each use data_sram_rdata in their single first cycle, with no bubble.

Reset
REQ-026 After rst: all register fields 0, first=0, hold_valid=0, rdata_hold=0.
REQ-027 After rst: dc_to_wb_bus=0, fwd_we=0, fwd_waddr=0, fwd_wdata=0, stallreq_load=0.
REQ-028 rst asserted mid-stall SHALL discard held load data in the same cycle.

Verification
REQ-029 ALU op: bus pc=0xBFC00000, rf_we=1, waddr=5, alu=0x1234, stall=0 -> next cycle dc_to_wb_bus rf_wdata=0x1234, fwd_we=1, fwd_waddr=5.
REQ-030 Load no stall: load to r8, rdata=0xDEADBEEF in DC cycle -> rf_wdata=0xDEADBEEF that cycle.
REQ-031 Load then stall[5:4]=2'b11 for 3 cycles, rdata changes to 0x0 after first cycle -> rf_wdata stays 0xDEADBEEF all 4 cycles, hold_valid=1 from cycle 2.
REQ-032 stall[4]=1, stall[5]=0 -> register zeroed, dc_to_wb_bus=0 next cycle.
REQ-033 flush with stall=6'b110000 while holding load -> register and hold_valid zero next cycle.
REQ-034 waddr=0, rf_we=1 -> fwd_we=0, dc_to_wb_bus rf_we=1.

Source files
------------

// File: rtl/dc_stage_if.sv
// Bus bundle between the data-cache (memory) stage and its neighbours:
// EX request bus, SRAM read data, WB bus, bypass port and load-stall request.
interface dc_stage_if;
   logic [75:0] ex_to_dc_bus;
   logic [31:0] data_sram_rdata;
   logic [69:0] dc_to_wb_bus;
   logic        fwd_we;
   logic [4:0]  fwd_waddr;
   logic [31:0] fwd_wdata;
   logic        stallreq_load;

   modport master (
      output ex_to_dc_bus,
      output data_sram_rdata,
      input  dc_to_wb_bus,
      input  fwd_we,
      input  fwd_waddr,
      input  fwd_wdata,
      input  stallreq_load
   );

   modport slave (
      input  ex_to_dc_bus,
      input  data_sram_rdata,
      output dc_to_wb_bus,
      output fwd_we,
      output fwd_waddr,
      output fwd_wdata,
      output stallreq_load
   );
endinterface

// File: rtl/dc_stage.sv
// Memory (DC) pipeline stage: registers the EX bus, selects load data or ALU
// result for write-back, and keeps SRAM read data alive across stalls.
module dc_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [5:0]  stall,
   dc_stage_if.slave   dc_if
);

   logic [31:0] pc_r;
   logic        data_ram_en_r;
   logic [3:0]  data_ram_wen_r;
   logic        sel_rf_res_r;
   logic        rf_we_r;
   logic [4:0]  rf_waddr_r;
   logic [31:0] alu_result_r;

   logic        first;
   logic        hold_valid;
   logic [31:0] rdata_hold;

   logic        stall_in;
   logic        stall_wb;
   logic        is_load;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        unused_stall;

   assign stall_in     = stall[4];
   assign stall_wb     = stall[5];
   assign unused_stall = ^stall[3:0];

   assign is_load = data_ram_en_r && (data_ram_wen_r == 4'b0000) && sel_rf_res_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r           <= '0;
         data_ram_en_r  <= 1'b0;
         data_ram_wen_r <= '0;
         sel_rf_res_r   <= 1'b0;
         rf_we_r        <= 1'b0;
         rf_waddr_r     <= '0;
         alu_result_r   <= '0;
         first          <= 1'b0;
         hold_valid     <= 1'b0;
         rdata_hold     <= '0;
      end else if (flush || (stall_in && !stall_wb)) begin
         // squash or bubble: downstream keeps moving, this stage empties
         pc_r           <= '0;
         data_ram_en_r  <= 1'b0;
         data_ram_wen_r <= '0;
         sel_rf_res_r   <= 1'b0;
         rf_we_r        <= 1'b0;
         rf_waddr_r     <= '0;
         alu_result_r   <= '0;
         first          <= 1'b0;
         hold_valid     <= 1'b0;
      end else if (!stall_in) begin
         pc_r           <= dc_if.ex_to_dc_bus[75:44];
         data_ram_en_r  <= dc_if.ex_to_dc_bus[43];
         data_ram_wen_r <= dc_if.ex_to_dc_bus[42:39];
         sel_rf_res_r   <= dc_if.ex_to_dc_bus[38];
         rf_we_r        <= dc_if.ex_to_dc_bus[37];
         rf_waddr_r     <= dc_if.ex_to_dc_bus[36:32];
         alu_result_r   <= dc_if.ex_to_dc_bus[31:0];
         first          <= 1'b1;
         hold_valid     <= 1'b0;
      end else begin
         first <= 1'b0;
         // SRAM data is only valid in the first cycle; keep it for the stall
         if (first && is_load) begin
            rdata_hold <= dc_if.data_sram_rdata;
            hold_valid <= 1'b1;
         end
      end
   end

   assign load_data = hold_valid ? rdata_hold : dc_if.data_sram_rdata;
   assign rf_wdata  = sel_rf_res_r ? load_data : alu_result_r;

   assign dc_if.dc_to_wb_bus  = {pc_r, rf_we_r, rf_waddr_r, rf_wdata};
   assign dc_if.fwd_we        = rf_we_r && (rf_waddr_r != 5'd0);
   assign dc_if.fwd_waddr     = rf_waddr_r;
   assign dc_if.fwd_wdata     = rf_wdata;
   assign dc_if.stallreq_load = is_load && rf_we_r && !first && !hold_valid;

endmodule

// File: tb/tb_dc_stage.sv
// Directed bench for dc_stage: ALU ops, loads with and without stalls,
// bubble, flush, r0 bypass suppression, stores and reset during a stall.
module tb_dc_stage;
   logic       clk;
   logic       rst;
   logic       flush;
   logic [5:0] stall;
   int         n_cmp;
   int         n_err;

   dc_stage_if bus_if ();

   dc_stage dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .stall (stall),
      .dc_if (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [75:0] got, input logic [75:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [75:0] mk_bus(input logic [31:0] pc, input logic en,
                                          input logic [3:0] wen, input logic sel,
                                          input logic we, input logic [4:0] waddr,
                                          input logic [31:0] alu);
      return {pc, en, wen, sel, we, waddr, alu};
   endfunction

   function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                         input logic [4:0] waddr, input logic [31:0] wdata);
      return {pc, we, waddr, wdata};
   endfunction

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      flush = 1'b0;
      stall = 6'b000000;
      bus_if.ex_to_dc_bus    = '0;
      bus_if.data_sram_rdata = 32'h0;
      tick();
      tick();
      rst = 1'b0;

      check_val("rst_wb",      bus_if.dc_to_wb_bus,  70'h0);
      check_val("rst_fwd_we",  bus_if.fwd_we,        1'b0);
      check_val("rst_fwd_wa",  bus_if.fwd_waddr,     5'd0);
      check_val("rst_fwd_wd",  bus_if.fwd_wdata,     32'h0);
      check_val("rst_stallrq", bus_if.stallreq_load, 1'b0);

      // ALU op
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
      tick();
      check_val("alu_wb",     bus_if.dc_to_wb_bus, mk_wb(32'hBFC00000, 1'b1, 5'd5, 32'h1234));
      check_val("alu_fwd_we", bus_if.fwd_we,       1'b1);
      check_val("alu_fwd_wa", bus_if.fwd_waddr,    5'd5);
      check_val("alu_fwd_wd", bus_if.fwd_wdata,    32'h1234);

      // load, no stall, then a back-to-back load
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC00004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h100);
      tick();
      bus_if.data_sram_rdata = 32'hDEADBEEF;
      #1;
      check_val("ld_wb",      bus_if.dc_to_wb_bus,  mk_wb(32'hBFC00004, 1'b1, 5'd8, 32'hDEADBEEF));
      check_val("ld_fwd_wd",  bus_if.fwd_wdata,     32'hDEADBEEF);
      check_val("ld_stallrq", bus_if.stallreq_load, 1'b0);

      bus_if.ex_to_dc_bus = mk_bus(32'hBFC00008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h104);
      tick();
      bus_if.data_sram_rdata = 32'hCAFEF00D;
      #1;
      check_val("ld_b2b_wb", bus_if.dc_to_wb_bus, mk_wb(32'hBFC00008, 1'b1, 5'd9, 32'hCAFEF00D));

      // load followed by a 3-cycle full stall; read data vanishes after cycle 1
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC0000C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h108);
      tick();
      bus_if.data_sram_rdata = 32'hDEADBEEF;
      #1;
      check_val("ldst_c1_wb", bus_if.dc_to_wb_bus, mk_wb(32'hBFC0000C, 1'b1, 5'd8, 32'hDEADBEEF));
      check_val("ldst_c1_hv", dut.hold_valid,      1'b0);
      stall = 6'b110000;
      bus_if.ex_to_dc_bus = mk_bus(32'h11111111, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h999);
      for (int c = 2; c <= 4; c++) begin
         tick();
         bus_if.data_sram_rdata = 32'h0;
         #1;
         check_val($sformatf("ldst_c%0d_wb", c), bus_if.dc_to_wb_bus,
                   mk_wb(32'hBFC0000C, 1'b1, 5'd8, 32'hDEADBEEF));
         check_val($sformatf("ldst_c%0d_hv", c), dut.hold_valid, 1'b1);
         check_val($sformatf("ldst_c%0d_sr", c), bus_if.stallreq_load, 1'b0);
      end

      // flush while stalled and holding
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("flush_wb",     bus_if.dc_to_wb_bus, 70'h0);
      check_val("flush_hv",     dut.hold_valid,      1'b0);
      check_val("flush_fwd_we", bus_if.fwd_we,       1'b0);

      // bubble: this stage stalled, WB free
      stall = 6'b000000;
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h77);
      tick();
      check_val("pre_bub_wb", bus_if.dc_to_wb_bus, mk_wb(32'hBFC00010, 1'b1, 5'd3, 32'h77));
      stall = 6'b010000;
      tick();
      check_val("bub_wb",     bus_if.dc_to_wb_bus, 70'h0);
      check_val("bub_fwd_we", bus_if.fwd_we,       1'b0);

      // write to r0: no bypass, WB still sees rf_we
      stall = 6'b000000;
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC00014, 1'b0, 4'h0, 1'b0, 1'b1, 5'd0, 32'hABC);
      tick();
      check_val("r0_fwd_we", bus_if.fwd_we,           1'b0);
      check_val("r0_wb_we",  bus_if.dc_to_wb_bus[37], 1'b1);
      check_val("r0_fwd_wd", bus_if.fwd_wdata,        32'hABC);

      // store: ALU result passes through, read data ignored
      bus_if.data_sram_rdata = 32'h55555555;
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC00018, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h2000);
      tick();
      check_val("st_wb", bus_if.dc_to_wb_bus, mk_wb(32'hBFC00018, 1'b0, 5'd0, 32'h2000));

      // reset in the middle of a stalled load
      bus_if.ex_to_dc_bus = mk_bus(32'hBFC0001C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h10C);
      tick();
      bus_if.data_sram_rdata = 32'h600DF00D;
      stall = 6'b110000;
      tick();
      bus_if.data_sram_rdata = 32'h0;
      #1;
      check_val("rstst_hv", dut.hold_valid, 1'b1);
      check_val("rstst_wb", bus_if.dc_to_wb_bus, mk_wb(32'hBFC0001C, 1'b1, 5'd10, 32'h600DF00D));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rstst_hv0",  dut.hold_valid,      1'b0);
      check_val("rstst_hold", dut.rdata_hold,      32'h0);
      check_val("rstst_wb0",  bus_if.dc_to_wb_bus, 70'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
